// File: rtl/frogger_pkg.sv
// Shared types and defaults for the frog round sequencer.
// Holds game states, move directions and the one-hot direction picker.
package frogger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        WIN,
        LOSE,
        OVER
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_L,
        DIR_U,
        DIR_D,
        DIR_R
    } dir_t;

    localparam int DEF_MAX_LIVES   = 3;
    localparam int DEF_SCORE_W     = 4;
    localparam int DEF_TIME_LIMIT  = 5000;
    localparam int DEF_HOLD_CYCLES = 200;

    // rise = {l, u, d, r}; anything but a single rise is no move
    function automatic dir_t pick_dir(input logic [3:0] rise);
        dir_t d;
        case (rise)
            4'b1000: d = DIR_L;
            4'b0100: d = DIR_U;
            4'b0010: d = DIR_D;
            4'b0001: d = DIR_R;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/frog_round_ctrl_key_edge.sv
// Rising-edge detector for one already-synchronized button level.
// Previous-value register clears on asynchronous reset.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= 1'b0;
        else       prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/frog_round_ctrl.sv
// Frog game round sequencer: move pulses, round outcome,
// round clear, score and lives.
module frog_round_ctrl
    import frogger_pkg::*;
#(
    parameter int MAX_LIVES   = DEF_MAX_LIVES,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int TIME_LIMIT  = DEF_TIME_LIMIT,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               keyL,
    input  logic               keyU,
    input  logic               keyD,
    input  logic               keyR,
    input  logic               frogTop,
    input  logic               hit,
    output logic               L,
    output logic               U,
    output logic               D,
    output logic               R,
    output logic               resetRound,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic               playing,
    output logic               winLed,
    output logic               gameOver
);

    localparam int TW = $clog2(TIME_LIMIT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t             state, nxt;
    logic [TW-1:0]      timer, timer_n;
    logic [HW-1:0]      hold, hold_n;
    logic [SCORE_W-1:0] score_n;
    logic [2:0]         lives_n;
    logic               rr_n;
    logic [3:0]         mv_n;
    logic               rs, rl, ru, rd, rk;
    dir_t               dir;

    key_edge u_start (.clk(clk), .reset(reset), .d(start), .rise(rs));
    key_edge u_l     (.clk(clk), .reset(reset), .d(keyL),  .rise(rl));
    key_edge u_u     (.clk(clk), .reset(reset), .d(keyU),  .rise(ru));
    key_edge u_d     (.clk(clk), .reset(reset), .d(keyD),  .rise(rd));
    key_edge u_r     (.clk(clk), .reset(reset), .d(keyR),  .rise(rk));

    always_comb begin
        nxt     = state;
        timer_n = timer;
        hold_n  = hold;
        score_n = score;
        lives_n = lives;
        dir     = pick_dir({rl, ru, rd, rk});
        case (state)
            IDLE: if (rs) nxt = PLAY;
            PLAY: begin
                if (timer != '0) timer_n = timer - TW'(1);
                // array contents are stale while resetRound is high
                if (timer == '0 || (!resetRound && hit)) begin
                    nxt     = LOSE;
                    lives_n = lives - 3'd1;
                end else if (!resetRound && frogTop) begin
                    nxt = WIN;
                    if (score != {SCORE_W{1'b1}})
                        score_n = score + SCORE_W'(1);
                end
            end
            WIN: begin
                if (hold == '0) nxt = PLAY;
                else            hold_n = hold - HW'(1);
            end
            LOSE: begin
                if (lives == 3'd0)     nxt = OVER;
                else if (hold == '0)   nxt = PLAY;
                else                   hold_n = hold - HW'(1);
            end
            OVER: begin
                if (rs) begin
                    nxt     = PLAY;
                    score_n = '0;
                    lives_n = 3'(MAX_LIVES);
                end
            end
            default: nxt = IDLE;
        endcase
        if (nxt == PLAY && state != PLAY)
            timer_n = TW'(TIME_LIMIT - 1);
        if (state == PLAY && (nxt == WIN || nxt == LOSE))
            hold_n = HW'(HOLD_CYCLES - 1);
        rr_n = (nxt == PLAY) && (state != PLAY);
        mv_n = 4'b0000;
        if (state == PLAY && nxt == PLAY) begin
            unique case (1'b1)
                (dir == DIR_L): mv_n = 4'b1000;
                (dir == DIR_U): mv_n = 4'b0100;
                (dir == DIR_D): mv_n = 4'b0010;
                (dir == DIR_R): mv_n = 4'b0001;
                default:        mv_n = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            hold         <= '0;
            score        <= '0;
            lives        <= 3'(MAX_LIVES);
            resetRound   <= 1'b0;
            {L, U, D, R} <= 4'b0000;
        end else begin
            state        <= nxt;
            timer        <= timer_n;
            hold         <= hold_n;
            score        <= score_n;
            lives        <= lives_n;
            resetRound   <= rr_n;
            {L, U, D, R} <= mv_n;
        end
    end

    assign playing  = (state == PLAY);
    assign winLed   = (state == WIN);
    assign gameOver = (state == OVER);

endmodule

// File: tb/tb_frog_round_ctrl.sv
// Directed bench for frog_round_ctrl: per-cycle vector table
// plus hand sequences for score saturation and async reset.
module tb_frog_round_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, keyL, keyU, keyD, keyR, frogTop, hit;
    logic       L, U, D, R, resetRound, playing, winLed, gameOver;
    logic [3:0] score;
    logic [2:0] lives;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0] in;   // {start,keyL,keyU,keyD,keyR,frogTop,hit}
        logic [7:0] out;  // {L,U,D,R,resetRound,playing,winLed,gameOver}
        int         sc;
        int         lv;
    } vec_t;

    vec_t tbl[36];

    frog_round_ctrl #(
        .MAX_LIVES(3),
        .SCORE_W(4),
        .TIME_LIMIT(8),
        .HOLD_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .keyL(keyL),
        .keyU(keyU),
        .keyD(keyD),
        .keyR(keyR),
        .frogTop(frogTop),
        .hit(hit),
        .L(L),
        .U(U),
        .D(D),
        .R(R),
        .resetRound(resetRound),
        .score(score),
        .lives(lives),
        .playing(playing),
        .winLed(winLed),
        .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {L, U, D, R, resetRound, playing, winLed, gameOver};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {start, keyL, keyU, keyD, keyR, frogTop, hit} = v;
    endtask

    task automatic step(input logic [6:0] v);
        drive(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{7'b0000000, 8'b00000000, 0, 3};
        tbl[1]  = '{7'b1000000, 8'b00001100, 0, 3};
        tbl[2]  = '{7'b1010000, 8'b01000100, 0, 3};
        tbl[3]  = '{7'b0010000, 8'b00000100, 0, 3};
        tbl[4]  = '{7'b0010000, 8'b00000100, 0, 3};
        tbl[5]  = '{7'b0110100, 8'b00000100, 0, 3};
        tbl[6]  = '{7'b0010000, 8'b00000100, 0, 3};
        tbl[7]  = '{7'b0110000, 8'b10000100, 0, 3};
        tbl[8]  = '{7'b0010010, 8'b00000010, 1, 3};
        tbl[9]  = '{7'b0010000, 8'b00000010, 1, 3};
        tbl[10] = '{7'b0010000, 8'b00000010, 1, 3};
        tbl[11] = '{7'b0010000, 8'b00000010, 1, 3};
        tbl[12] = '{7'b0000000, 8'b00001100, 1, 3};
        tbl[13] = '{7'b0000011, 8'b00000100, 1, 3};
        tbl[14] = '{7'b0000011, 8'b00000000, 1, 2};
        tbl[15] = '{7'b0000000, 8'b00000000, 1, 2};
        tbl[16] = '{7'b0000000, 8'b00000000, 1, 2};
        tbl[17] = '{7'b0000000, 8'b00000000, 1, 2};
        tbl[18] = '{7'b0000000, 8'b00001100, 1, 2};
        tbl[19] = '{7'b0000000, 8'b00000100, 1, 2};
        tbl[20] = '{7'b0001000, 8'b00100100, 1, 2};
        tbl[21] = '{7'b1000000, 8'b00000100, 1, 2};
        tbl[22] = '{7'b0000100, 8'b00010100, 1, 2};
        tbl[23] = '{7'b0000000, 8'b00000100, 1, 2};
        tbl[24] = '{7'b0000000, 8'b00000100, 1, 2};
        tbl[25] = '{7'b0000000, 8'b00000100, 1, 2};
        tbl[26] = '{7'b0000000, 8'b00000000, 1, 1};
        tbl[27] = '{7'b0000000, 8'b00000000, 1, 1};
        tbl[28] = '{7'b0000000, 8'b00000000, 1, 1};
        tbl[29] = '{7'b0000000, 8'b00000000, 1, 1};
        tbl[30] = '{7'b0000000, 8'b00001100, 1, 1};
        tbl[31] = '{7'b0000000, 8'b00000100, 1, 1};
        tbl[32] = '{7'b0000001, 8'b00000000, 1, 0};
        tbl[33] = '{7'b0000000, 8'b00000001, 1, 0};
        tbl[34] = '{7'b0100000, 8'b00000001, 1, 0};
        tbl[35] = '{7'b1000000, 8'b00001100, 0, 3};

        reset = 1'b1;
        drive(7'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", int'(outs()), 0);
        check("rst_score", int'(score), 0);
        check("rst_lives", int'(lives), 3);
        reset = 1'b0;

        for (int i = 0; i < 36; i++) begin
            step(tbl[i].in);
            check($sformatf("v%0d_outs", i), int'(outs()), int'(tbl[i].out));
            check($sformatf("v%0d_score", i), int'(score), tbl[i].sc);
            check($sformatf("v%0d_lives", i), int'(lives), tbl[i].lv);
        end

        // sixteen wins in a row: score saturates at 15
        for (int i = 1; i <= 16; i++) begin
            step(7'b0000000);
            check($sformatf("sat%0d_play", i), int'(outs()), 8'b00000100);
            step(7'b0000010);
            check($sformatf("sat%0d_win", i), int'(outs()), 8'b00000010);
            check($sformatf("sat%0d_score", i), int'(score), (i > 15) ? 15 : i);
            repeat (3) step(7'b0000000);
            step(7'b0000000);
            check($sformatf("sat%0d_rr", i), int'(outs()), 8'b00001100);
        end
        check("sat_lives", int'(lives), 3);

        // async reset in the middle of a WIN hold
        step(7'b0000000);
        step(7'b0000010);
        check("hold_win", int'(outs()), 8'b00000010);
        step(7'b0000000);
        #2;
        reset = 1'b1;
        #1;
        check("async_outs", int'(outs()), 0);
        check("async_score", int'(score), 0);
        check("async_lives", int'(lives), 3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(7'b0000000);
            check($sformatf("post_idle%0d", i), int'(outs()), 0);
        end
        step(7'b1000000);
        check("post_start", int'(outs()), 8'b00001100);
        step(7'b1000000);
        check("post_play", int'(outs()), 8'b00000100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
